// File: rtl/title_text_if.sv
// Pixel, control, string-write and font-ROM signals of the title text layer.
// master = video timing / CPU / ROM side, slave = title_text_engine.
interface title_text_if;
    logic        video_on;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        frame_tick;
    logic [1:0]  mode;
    logic        restart;
    logic        str_we;
    logic [3:0]  str_idx;
    logic [6:0]  str_char;
    logic [10:0] rom_addr;
    logic [7:0]  font_word;
    logic        text_on;
    logic [2:0]  rgb_text;
    logic        reveal_done;

    modport master (
        output video_on, pixel_x, pixel_y, frame_tick, mode, restart,
               str_we, str_idx, str_char, font_word,
        input  rom_addr, text_on, rgb_text, reveal_done
    );

    modport slave (
        input  video_on, pixel_x, pixel_y, frame_tick, mode, restart,
               str_we, str_idx, str_char, font_word,
        output rom_addr, text_on, rgb_text, reveal_done
    );
endinterface

// File: rtl/title_text_engine.sv
// Scaled 8x16-font title string renderer with a writable string buffer and
// static / blink / typewriter display modes; fixed 2-cycle pixel latency.
module title_text_engine #(
    parameter int          N_CHARS       = 5,
    parameter int          SCALE_LOG2    = 2,
    parameter int          X0            = 256,
    parameter int          Y0            = 32,
    parameter logic [2:0]  COLOR         = 3'b111,
    parameter int          BLINK_FRAMES  = 30,
    parameter int          REVEAL_FRAMES = 8
) (
    input  logic   clk,
    input  logic   reset_n,
    title_text_if.slave bus
);
    localparam int CELL_W = 8 << SCALE_LOG2;
    localparam int CELL_H = 16 << SCALE_LOG2;
    localparam int X_END  = X0 + N_CHARS * CELL_W;
    localparam int Y_END  = Y0 + CELL_H;
    localparam int RW     = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if (X_END > 640 || Y_END > 480) begin : g_bad_geometry
        $error("title string does not fit on the 640x480 screen");
    end

    logic [6:0]  r_buf [N_CHARS];
    logic [10:0] w_dx, w_dy;
    logic        w_in_region;
    logic [3:0]  w_char_idx;
    logic [2:0]  w_col;
    logic [3:0]  w_row;
    logic [6:0]  w_sel_char;

    logic        r_in_region_d, r_video_on_d;
    logic [2:0]  r_col_d;
    logic [3:0]  r_char_idx_d;

    logic [RW-1:0] r_reveal_frm;
    logic [4:0]    r_reveal_cnt;
    logic          r_reveal_done;
    logic [BW-1:0] r_blink_frm;
    logic          r_phase;
    logic          w_blink_hold;

    logic        w_char_visible, w_blink_visible, w_lit;
    logic        r_text_on;
    logic [2:0]  r_rgb_text;

    assign w_dx = {1'b0, bus.pixel_x} - 11'(X0);
    assign w_dy = {1'b0, bus.pixel_y} - 11'(Y0);
    assign w_in_region = ({1'b0, bus.pixel_x} >= 11'(X0)) && ({1'b0, bus.pixel_x} < 11'(X_END)) &&
                         ({1'b0, bus.pixel_y} >= 11'(Y0)) && ({1'b0, bus.pixel_y} < 11'(Y_END));
    assign w_char_idx = 4'(w_dx >> (3 + SCALE_LOG2));
    assign w_col      = 3'(w_dx >> SCALE_LOG2);
    assign w_row      = 4'(w_dy >> SCALE_LOG2);

    always_comb begin
        w_sel_char = 7'h00;
        for (int i = 0; i < N_CHARS; i++) begin
            if (w_char_idx == 4'(i)) w_sel_char = r_buf[i];
        end
    end

    assign bus.rom_addr = w_in_region ? {w_sel_char, w_row} : 11'd0;

    // Slots at or beyond N_CHARS never match, so out-of-range writes drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CHARS; i++) r_buf[i] <= 7'h20;
        end else begin
            for (int i = 0; i < N_CHARS; i++) begin
                if (bus.str_we && bus.str_idx == 4'(i)) r_buf[i] <= bus.str_char;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_region_d <= 1'b0;
            r_video_on_d  <= 1'b0;
            r_col_d       <= 3'd0;
            r_char_idx_d  <= 4'd0;
        end else begin
            r_in_region_d <= w_in_region;
            r_video_on_d  <= bus.video_on;
            r_col_d       <= w_col;
            r_char_idx_d  <= w_char_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reveal_frm  <= '0;
            r_reveal_cnt  <= 5'd0;
            r_reveal_done <= 1'b0;
        end else if (bus.restart) begin
            r_reveal_frm  <= '0;
            r_reveal_cnt  <= 5'd0;
            r_reveal_done <= 1'b0;
        end else if (bus.frame_tick && !r_reveal_done) begin
            if (r_reveal_frm == RW'(REVEAL_FRAMES - 1)) begin
                r_reveal_frm  <= '0;
                r_reveal_cnt  <= r_reveal_cnt + 5'd1;
                r_reveal_done <= (r_reveal_cnt == 5'(N_CHARS - 1));
            end else begin
                r_reveal_frm <= r_reveal_frm + RW'(1);
            end
        end
    end

    // In typewriter-then-blink the blink timer only starts once the string is complete.
    assign w_blink_hold = (bus.mode == 2'd3) && !r_reveal_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_frm <= '0;
            r_phase     <= 1'b1;
        end else if (bus.restart || w_blink_hold) begin
            r_blink_frm <= '0;
            r_phase     <= 1'b1;
        end else if (bus.frame_tick) begin
            if (r_blink_frm == BW'(BLINK_FRAMES - 1)) begin
                r_blink_frm <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_frm <= r_blink_frm + BW'(1);
            end
        end
    end

    always_comb begin
        w_char_visible  = (bus.mode < 2'd2) || ({1'b0, r_char_idx_d} < r_reveal_cnt);
        w_blink_visible = 1'b1;
        case (bus.mode)
            2'd1:    w_blink_visible = r_phase;
            2'd3:    w_blink_visible = !r_reveal_done || r_phase;
            default: w_blink_visible = 1'b1;
        endcase
        w_lit = r_video_on_d && r_in_region_d && bus.font_word[3'd7 - r_col_d] &&
                w_char_visible && w_blink_visible;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_text_on  <= 1'b0;
            r_rgb_text <= 3'b000;
        end else begin
            r_text_on  <= w_lit;
            r_rgb_text <= w_lit ? COLOR : 3'b000;
        end
    end

    assign bus.text_on     = r_text_on;
    assign bus.rgb_text    = r_rgb_text;
    assign bus.reveal_done = r_reveal_done;
endmodule
